// File: rtl/aq_djpeg_pixel_writer.sv
// aq_djpeg_pixel_writer
// Takes RGB pixels with (X,Y) coordinates from the colour converter and drops
// padding pixels that lie outside the visible image. For each remaining pixel it
// computes a frame-buffer byte address and an XRGB8888 word. The address/word
// pairs are queued in a small first-word-fall-through FIFO and issued as memory
// writes. A frame FSM counts the completed writes and pulses FrameDone once the
// visible area has been written.

module aq_djpeg_pixel_writer #(
  parameter int FIFO_AW = 4,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FrameStart,
  input  logic [ADDR_W-1:0] FrameBase,
  input  logic [15:0]       ImageWidth,
  input  logic [15:0]       ImageHeight,
  input  logic [15:0]       Stride,
  input  logic              InEnable,
  output logic              InReady,
  input  logic [15:0]       InPixelX,
  input  logic [15:0]       InPixelY,
  input  logic [7:0]        InR,
  input  logic [7:0]        InG,
  input  logic [7:0]        InB,
  output logic              WrValid,
  input  logic              WrReady,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [31:0]       WrData,
  output logic              Busy,
  output logic              FrameDone
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int ENT_W = ADDR_W + 24;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // latched frame configuration
  logic [ADDR_W-1:0]   r_base;
  logic [15:0]         r_width;
  logic [15:0]         r_height;
  logic [15:0]         r_stride;
  logic [31:0]         r_total;
  logic                r_total_vld;
  logic [31:0]         r_wrcount;

  // pipeline stages
  logic                r_vld_p0;
  logic [15:0]         r_x_p0;
  logic [15:0]         r_y_p0;
  logic [23:0]         r_rgb_p0;
  logic                r_vld_p1;
  logic [ADDR_W-1:0]   r_addr_p1;
  logic [23:0]         r_rgb_p1;

  // write FIFO
  logic [ENT_W-1:0]    r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wptr;
  logic [FIFO_AW-1:0]  r_rptr;
  logic [FIFO_AW:0]    r_count;

  logic                w_accept;
  logic                w_in_range;
  logic                w_push;
  logic                w_pop;
  logic [FIFO_AW+1:0]  w_inflight;
  logic [ENT_W-1:0]    w_head;

  // Byte address of pixel (x,y): base + 4*(y*stride + x), wrapped to ADDR_W.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [15:0]       x,
                                                 input logic [15:0]       y,
                                                 input logic [15:0]       stride);
    logic [31:0]       offs;
    logic [ADDR_W-1:0] boffs;
    offs  = {16'd0, y} * {16'd0, stride} + {16'd0, x};
    boffs = ADDR_W'({offs, 2'b00});
    return base + boffs;
  endfunction

  // Every pixel already accepted but not yet written owns one FIFO slot, so
  // the two pipeline stages can always push without stalling.
  assign w_inflight = (FIFO_AW+2)'(r_count) + (FIFO_AW+2)'(r_vld_p0) + (FIFO_AW+2)'(r_vld_p1);
  assign InReady    = Busy && (w_inflight < (FIFO_AW+2)'(DEPTH));
  assign w_accept   = InEnable && InReady;
  assign w_in_range = (InPixelX < r_width) && (InPixelY < r_height);
  assign w_push     = r_vld_p1;
  assign w_pop      = WrValid && WrReady;

  // Head entry is presented directly; outputs read as zero while the FIFO is empty.
  assign w_head  = r_mem[r_rptr];
  assign WrValid = (r_count != '0);
  assign WrAddr  = WrValid ? w_head[ENT_W-1:24] : '0;
  assign WrData  = WrValid ? {8'h00, w_head[23:0]} : '0;

  // Frame configuration, visible-pixel total and completed-write counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base      <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_stride    <= '0;
      r_total     <= '0;
      r_total_vld <= 1'b0;
      r_wrcount   <= '0;
    end else if (FrameStart) begin
      r_base      <= FrameBase;
      r_width     <= ImageWidth;
      r_height    <= ImageHeight;
      r_stride    <= Stride;
      r_total_vld <= 1'b0;
      r_wrcount   <= '0;
    end else begin
      r_total     <= {16'd0, r_width} * {16'd0, r_height};
      r_total_vld <= 1'b1;
      r_wrcount   <= r_wrcount + 32'(w_pop);
    end
  end

  // Stage valids: clipped pixels never enter, FrameStart empties both stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else if (FrameStart) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept && w_in_range;
      r_vld_p1 <= r_vld_p0;
    end
  end

  // Stage data, qualified only by the valids above.
  always_ff @(posedge clk) begin
    // p0: capture pixel
    r_x_p0    <= InPixelX;
    r_y_p0    <= InPixelY;
    r_rgb_p0  <= {InR, InG, InB};
    // p1: frame-buffer address
    r_addr_p1 <= pix_addr(r_base, r_x_p0, r_y_p0, r_stride);
    r_rgb_p1  <= r_rgb_p0;
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_addr_p1, r_rgb_p1};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (FrameStart) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state: FrameStart always restarts; RUN ends on the write that reaches the total.
  always_comb begin
    w_state_nxt = r_state;
    if (FrameStart) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_RUN:  if (r_total_vld && ((r_wrcount + 32'(w_pop)) == r_total)) w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Frame status outputs decoded from the state.
  always_comb begin
    Busy      = 1'b0;
    FrameDone = 1'b0;
    case (r_state)
      ST_RUN:  Busy      = 1'b1;
      ST_DONE: FrameDone = 1'b1;
      default: ;
    endcase
  end

endmodule
